// File: rtl/request_conditioner.sv
// request_conditioner: front end of the intersection controller.
// Each channel synchronises and debounces a raw input, then holds a sticky
// request until the matching green is seen.
// Optional build macro REQ_OVERDUE_EN adds a per-channel wait counter. The
// sticky overdue flag sets once any request has waited more than MAX_WAIT
// cycles. Without the macro, overdue is tied low.
module request_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_WAIT        = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic ped_button_raw,
    input  logic turn_sensor_raw,
    input  logic pedestrian_green,
    input  logic turn_green,
    output logic pedestrian_button,
    output logic turn_sensor,
    output logic overdue
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StServing = 2'd2
    } state_e;

    // Channel 0 is pedestrian, channel 1 is turn lane.
    logic [1:0] raw;
    logic [1:0] green;
    logic [1:0] req;

    assign raw   = {turn_sensor_raw, ped_button_raw};
    assign green = {turn_green, pedestrian_green};

`ifdef REQ_OVERDUE_EN
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1) + 1;
    logic [1:0] late;
`endif

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   sync;
        logic                   deb_q, deb_d;
        logic [CntW-1:0]        cnt_q, cnt_d;
        logic                   rise_q, rise_d;
        state_e                 state_q, state_d;
        logic                   req_q, req_d;

        assign sync = sync_q[SYNC_STAGES-1];

        // Shift the raw input through the synchroniser chain.
        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], raw[c]};
        end

        // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync != deb_q) begin
                if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d = ~deb_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            rise_d = deb_d & ~deb_q;
        end

        // Request FSM: a rise raises a request unless green is already on.
        always_comb begin
            state_d = state_q;
            case (state_q)
                StIdle: begin
                    if (rise_q) begin
                        state_d = green[c] ? StServing : StPending;
                    end
                end
                StPending: begin
                    if (green[c]) begin
                        state_d = StServing;
                    end
                end
                StServing: begin
                    // A button still held here must be released and pressed again.
                    if (!green[c]) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
            req_d = (state_d == StPending);
        end

        // Channel state registers.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync_q  <= '0;
                deb_q   <= 1'b0;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                state_q <= StIdle;
                req_q   <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                deb_q   <= deb_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                state_q <= state_d;
                req_q   <= req_d;
            end
        end

        assign req[c] = req_q;

`ifdef REQ_OVERDUE_EN
        logic [WaitW-1:0] wait_q, wait_d;

        // Saturating count of cycles spent in PENDING; cleared in any other state.
        always_comb begin
            wait_d = '0;
            if (state_q == StPending) begin
                wait_d = (wait_q == {WaitW{1'b1}}) ? wait_q : wait_q + 1'b1;
            end
        end

        // Wait counter register.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_d;
            end
        end

        assign late[c] = (wait_d > WaitW'(MAX_WAIT));
`endif
    end

    assign pedestrian_button = req[0];
    assign turn_sensor       = req[1];

`ifdef REQ_OVERDUE_EN
    logic overdue_q, overdue_d;

    // Overdue is sticky until reset.
    always_comb begin
        overdue_d = overdue_q | (|late);
    end

    // Overdue flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overdue_q <= 1'b0;
        end else begin
            overdue_q <= overdue_d;
        end
    end

    assign overdue = overdue_q;
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
    assign overdue         = 1'b0;
`endif

endmodule

// File: tb/tb_request_conditioner.sv
// Self-checking bench for request_conditioner: directed scenarios followed by
// random stimulus, all compared against a sample-history reference model.
module tb_request_conditioner;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned DebCycles  = 4;
    localparam int unsigned MaxWait    = 25;

    localparam int MIdle = 0;
    localparam int MPend = 1;
    localparam int MServ = 2;

`ifdef REQ_OVERDUE_EN
    localparam bit OdBuilt = 1'b1;
`else
    localparam bit OdBuilt = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic ped_button_raw;
    logic turn_sensor_raw;
    logic pedestrian_green;
    logic turn_green;
    logic pedestrian_button;
    logic turn_sensor;
    logic overdue;

    request_conditioner #(
        .SYNC_STAGES    (SyncStages),
        .DEBOUNCE_CYCLES(DebCycles),
        .MAX_WAIT       (MaxWait)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ped_button_raw   (ped_button_raw),
        .turn_sensor_raw  (turn_sensor_raw),
        .pedestrian_green (pedestrian_green),
        .turn_green       (turn_green),
        .pedestrian_button(pedestrian_button),
        .turn_sensor      (turn_sensor),
        .overdue          (overdue)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw sample history per channel, debounced level,
    // pending rise, request state, pending-run length and overdue flag.
    bit m_hist[2][$];
    bit m_level[2];
    bit m_rise[2];
    int m_st[2];
    int m_wait[2];
    bit m_od;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_hist[c].delete();
            m_level[c] = 1'b0;
            m_rise[c]  = 1'b0;
            m_st[c]    = MIdle;
            m_wait[c]  = 0;
        end
        m_od = 1'b0;
    endfunction

    function automatic void model_edge();
        bit raw[2];
        bit grn[2];
        raw[0] = ped_button_raw;
        raw[1] = turn_sensor_raw;
        grn[0] = pedestrian_green;
        grn[1] = turn_green;
        for (int c = 0; c < 2; c++) begin
            int  old;
            bit  all_diff;
            int  sz;
            old = m_st[c];
            case (old)
                MIdle:   if (m_rise[c]) m_st[c] = grn[c] ? MServ : MPend;
                MPend:   if (grn[c]) m_st[c] = MServ;
                default: if (!grn[c]) m_st[c] = MIdle;
            endcase
            // Cycles a request has been outstanding as of this edge.
            if (old == MPend) m_wait[c]++;
            else m_wait[c] = 0;
            if (m_wait[c] > int'(MaxWait)) m_od = 1'b1;
            // The level flips when the last DebCycles synchronised samples
            // (raw delayed by SyncStages edges) all disagree with it.
            m_hist[c].push_back(raw[c]);
            if (m_hist[c].size() > 32) void'(m_hist[c].pop_front());
            sz = m_hist[c].size();
            all_diff = 1'b1;
            for (int j = 0; j < int'(DebCycles); j++) begin
                int idx;
                bit s;
                idx = sz - 1 - j - int'(SyncStages);
                s = (idx >= 0) ? m_hist[c][idx] : 1'b0;
                if (s == m_level[c]) all_diff = 1'b0;
            end
            m_rise[c] = 1'b0;
            if (all_diff) begin
                m_level[c] = ~m_level[c];
                m_rise[c]  = m_level[c];
            end
        end
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_eq("ped_req", pedestrian_button, m_st[0] == MPend);
        check_eq("turn_req", turn_sensor, m_st[1] == MPend);
        check_eq("overdue", overdue, OdBuilt & m_od);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_ped", pedestrian_button, 1'b0);
        check_eq("rst_turn", turn_sensor, 1'b0);
        check_eq("rst_overdue", overdue, 1'b0);
        model_reset();
        #2 reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        ped_button_raw   = 1'b0;
        turn_sensor_raw  = 1'b0;
        pedestrian_green = 1'b0;
        turn_green       = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_ped", pedestrian_button, 1'b0);
        check_eq("reset_turn", turn_sensor, 1'b0);
        check_eq("reset_overdue", overdue, 1'b0);
        reset = 1'b0;

        // Latency: held press first sampled at edge 0, request after edge 6.
        ped_button_raw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("latency", pedestrian_button, i == 6);
        end
        steps(3);
        check_eq("sticky", pedestrian_button, 1'b1);

        // Grant drops the request; a held button does not re-request.
        pedestrian_green = 1'b1;
        step();
        check_eq("grant_drop", pedestrian_button, 1'b0);
        steps(3);
        pedestrian_green = 1'b0;
        steps(12);
        check_eq("held_no_rereq", pedestrian_button, 1'b0);
        ped_button_raw = 1'b0;
        steps(10);
        ped_button_raw = 1'b1;
        steps(6);
        check_eq("repress_early", pedestrian_button, 1'b0);
        step();
        check_eq("repress", pedestrian_button, 1'b1);
        pedestrian_green = 1'b1;
        step();
        pedestrian_green = 1'b0;
        ped_button_raw   = 1'b0;
        steps(10);

        // Debounce: 3-cycle glitch is filtered, 4 stable cycles are accepted.
        turn_sensor_raw = 1'b1;
        steps(3);
        turn_sensor_raw = 1'b0;
        steps(12);
        check_eq("glitch3", turn_sensor, 1'b0);
        turn_sensor_raw = 1'b1;
        steps(4);
        turn_sensor_raw = 1'b0;
        steps(6);
        check_eq("pulse4", turn_sensor, 1'b1);
        turn_green = 1'b1;
        step();
        turn_green = 1'b0;
        steps(10);

        // Green already on at the rise: no request, then back to idle.
        turn_green      = 1'b1;
        turn_sensor_raw = 1'b1;
        steps(12);
        check_eq("green_first", turn_sensor, 1'b0);
        turn_green = 1'b0;
        step();
        turn_sensor_raw = 1'b0;
        steps(10);
        turn_sensor_raw = 1'b1;
        steps(7);
        check_eq("after_serving", turn_sensor, 1'b1);
        turn_green = 1'b1;
        step();
        turn_green      = 1'b0;
        turn_sensor_raw = 1'b0;
        steps(10);

        // Asynchronous reset mid-PENDING, then no request without a new press.
        ped_button_raw  = 1'b1;
        turn_sensor_raw = 1'b1;
        steps(8);
        check_eq("pre_rst_ped", pedestrian_button, 1'b1);
        check_eq("pre_rst_turn", turn_sensor, 1'b1);
        #3 reset = 1'b1;
        #1;
        check_eq("async_rst_ped", pedestrian_button, 1'b0);
        check_eq("async_rst_turn", turn_sensor, 1'b0);
        model_reset();
        ped_button_raw  = 1'b0;
        turn_sensor_raw = 1'b0;
        #2 reset = 1'b0;
        steps(12);
        check_eq("no_req_after_rst_ped", pedestrian_button, 1'b0);
        check_eq("no_req_after_rst_turn", turn_sensor, 1'b0);

        // Overdue: a long-waiting request sets the flag (if built), sticky past the grant.
        ped_button_raw = 1'b1;
        steps(7);
        ped_button_raw = 1'b0;
        steps(30);
        check_eq("overdue_set", overdue, OdBuilt);
        pedestrian_green = 1'b1;
        step();
        pedestrian_green = 1'b0;
        steps(5);
        check_eq("overdue_sticky", overdue, OdBuilt);
        step();
        mid_reset();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 5) == 0) ped_button_raw = ~ped_button_raw;
            if ($urandom_range(0, 5) == 0) turn_sensor_raw = ~turn_sensor_raw;
            if ($urandom_range(0, 9) == 0) pedestrian_green = ~pedestrian_green;
            if ($urandom_range(0, 9) == 0) turn_green = ~turn_green;
            if ($urandom_range(0, 399) == 0) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
